// File: rtl/dac_wave_gen.sv
// Waveform sample source for the I2C DAC FSM: ticks at clk/TICK_DIV, computes
// sawtooth/triangle/square/constant codes and offers them over valid/ready.
module dac_wave_gen #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_mode,
    input  logic [3:0]  i_step,
    input  logic [7:0]  i_level,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_overrun,
    output logic [15:0] o_sample_cnt
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_SAW   = 2'd0;
    localparam logic [1:0] MODE_TRI   = 2'd1;
    localparam logic [1:0] MODE_SQR   = 2'd2;

    logic [CNT_W-1:0] div_q, div_d;
    logic [7:0]       phase_q, phase_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             tick;
    logic             xfer;
    logic [7:0]       step_eff;
    logic [7:0]       code;

    assign tick     = (div_q == DIV_LAST);
    assign xfer     = valid_q & i_ready;
    assign step_eff = (i_step == 4'd0) ? 8'd1 : {4'd0, i_step};

    always_comb begin
        case (i_mode)
            MODE_SAW: code = phase_q;
            MODE_TRI: code = phase_q[7] ? ~{phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
            MODE_SQR: code = phase_q[7] ? 8'hFF : 8'h00;
            default:  code = i_level;
        endcase
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        phase_d = phase_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q + {15'd0, xfer};

        if (xfer) begin
            valid_d = 1'b0;
        end
        // Phase advances on every tick so the waveform stays time-true even
        // when the DAC side stalls and samples are dropped.
        if (tick) begin
            phase_d = phase_q + step_eff;
            if (!valid_q || i_ready) begin
                data_d  = code;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q   <= '0;
            phase_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_overrun    = ovr_q;
    assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Randomized scoreboard bench for dac_wave_gen with a small TICK_DIV.
module tb_dac_wave_gen;

    localparam int unsigned TDIV = 4;

    logic        clk;
    logic        i_rst;
    logic [1:0]  i_mode;
    logic [3:0]  i_step;
    logic [7:0]  i_level;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_overrun;
    logic [15:0] o_sample_cnt;

    dac_wave_gen #(.TICK_DIV(TDIV), .CNT_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_mode       (i_mode),
        .i_step       (i_step),
        .i_level      (i_level),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_overrun    (o_overrun),
        .o_sample_cnt (o_sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: values expected after the most recent edge.
    logic [7:0] sb_q[$];
    int  m_phase = 0;
    int  m_div   = 0;
    int  m_cnt   = 0;
    bit  m_pend  = 0;
    bit  m_ovr   = 0;
    bit  known   = 0;
    bit  just_rst = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_code(input logic [1:0] m, input int p, input logic [7:0] lv);
        case (m)
            2'd0:    return 8'(p);
            2'd1:    return (p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128));
            2'd2:    return (p >= 128) ? 8'hFF : 8'h00;
            default: return lv;
        endcase
    endfunction

    function automatic bit next_is_tick();
        return m_div == int'(TDIV) - 1;
    endfunction

    // Checks the state after the previous edge, applies inputs, advances the model.
    task automatic step_cycle(input bit rst, input bit rdy, input logic [1:0] md,
                              input logic [3:0] st, input logic [7:0] lv);
        bit tick;
        bit xfer;
        if (known) begin
            chk("valid", int'(o_valid), int'(m_pend));
            chk("overrun", int'(o_overrun), int'(m_ovr));
            chk("sample_cnt", int'(o_sample_cnt), m_cnt);
            if (just_rst) chk("data_after_reset", int'(o_data), 0);
        end
        just_rst = 0;
        i_rst   = rst;
        i_ready = rdy;
        i_mode  = md;
        i_step  = st;
        i_level = lv;
        if (rst) begin
            sb_q.delete();
            m_phase = 0; m_div = 0; m_cnt = 0; m_pend = 0; m_ovr = 0;
            known = 1; just_rst = 1;
        end else begin
            tick  = next_is_tick();
            m_div = tick ? 0 : m_div + 1;
            xfer  = m_pend && rdy;
            if (xfer) m_cnt = (m_cnt + 1) % 65536;
            if (tick) begin
                if (!m_pend || rdy) begin
                    sb_q.push_back(ref_code(md, m_phase, lv));
                    m_pend = 1;
                end else begin
                    m_ovr = 1;
                end
                m_phase = (m_phase + ((st == 4'd0) ? 1 : int'(st))) % 256;
            end else if (xfer) begin
                m_pend = 0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: whenever a sample is presented it must be the oldest expected one;
    // it is retired when the DAC side accepts it.
    always @(negedge clk) begin
        if (known && !i_rst && o_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL data_unexpected got %0h expected none at %0t", o_data, $time);
            end else begin
                chk("data", int'(o_data), int'(sb_q[0]));
                if (i_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_ready = 1'b0; i_mode = '0; i_step = '0; i_level = '0;

        // Sawtooth, step 0 acting as 1, always ready: 257 samples.
        step_cycle(1, 0, 2'd0, 4'd0, 8'h00);
        for (int i = 0; i < 257 * int'(TDIV) + 1; i++) step_cycle(0, 1, 2'd0, 4'd0, 8'h00);
        chk("cnt_257", int'(o_sample_cnt), 257);

        // Random modes, steps, levels and ready.
        for (int i = 0; i < 2000; i++)
            step_cycle(0, ($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 8'($urandom));

        // Backpressure after the first sample of a fresh sawtooth.
        step_cycle(1, 0, 2'd0, 4'd1, 8'h00);
        for (int i = 0; i < 14; i++) step_cycle(0, 0, 2'd0, 4'd1, 8'h00);
        chk("bp_data_held", int'(o_data), 0);
        chk("bp_overrun", int'(o_overrun), 1);
        step_cycle(0, 1, 2'd0, 4'd1, 8'h00);
        step_cycle(0, 0, 2'd0, 4'd1, 8'h00);
        chk("bp_next_sample", int'(o_data), 3);
        for (int i = 0; i < 5; i++) step_cycle(0, 0, 2'd0, 4'd1, 8'h00);

        // Reset while a sample is pending and overrun is set.
        step_cycle(1, 1, 2'd0, 4'd1, 8'h00);
        for (int i = 0; i < 40; i++) step_cycle(0, ($urandom_range(0, 1) == 1), 2'd0, 4'd1, 8'h00);

        // Constant level with ready only on tick cycles: back-to-back, no overrun.
        step_cycle(1, 0, 2'd3, 4'd0, 8'hA5);
        for (int i = 0; i < 200; i++) step_cycle(0, next_is_tick(), 2'd3, 4'($urandom), 8'hA5);
        chk("const_no_overrun", int'(o_overrun), 0);

        // Heavy random backpressure with random resets.
        for (int i = 0; i < 1500; i++)
            step_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                       2'($urandom), 4'($urandom), 8'($urandom));

        // Drain: always ready, then nothing may be left but the pending sample.
        for (int i = 0; i < 3 * int'(TDIV); i++) step_cycle(0, 1, 2'd1, 4'd5, 8'h00);
        chk("scoreboard_left", sb_q.size(), int'(m_pend));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
